// File: rtl/dmem_sequencer.sv
// Data-memory access sequencer for the MEM stage: issues one request per load/store,
// stalls the pipeline until ack or timeout, and tracks halt/error as terminal states.
module dmem_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        halt_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        stall_o,
    output logic        halted_o,
    output logic        err_o,
    output logic [15:0] acc_cnt_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_HALTED,
        S_ERR
    } state_t;

    state_t        state_q;
    logic          req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          rvld_q;
    logic          halted_q;
    logic          err_q;
    logic [15:0]   acc_cnt_q;
    logic [15:0]   acc_cnt_d;
    logic [CW-1:0] tmo_q;
    logic [CW-1:0] tmo_d;
    logic          mem_op;

    assign mem_op    = mem_read_i | mem_write_i;
    assign acc_cnt_d = acc_cnt_q + 16'd1;
    assign tmo_d     = tmo_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rvld_q    <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            acc_cnt_q <= '0;
            tmo_q     <= '0;
        end else begin
            rvld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A memory op takes priority over halt; halt is re-seen after DONE.
                    if (mem_read_i && mem_write_i) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (mem_op) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        we_q    <= mem_write_i;
                        tmo_q   <= '0;
                        req_q   <= 1'b1;
                        state_q <= S_WAIT;
                    end else if (halt_i) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALTED;
                    end
                end
                S_WAIT: begin
                    if (mem_ack_i) begin
                        req_q     <= 1'b0;
                        rvld_q    <= ~we_q;
                        acc_cnt_q <= acc_cnt_d;
                        if (!we_q) rdata_q <= mem_rdata_i;
                        state_q   <= S_DONE;
                    end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= state_q;
            endcase
        end
    end

    assign stall_o = ((state_q == S_IDLE) && mem_op) ||
                     (state_q == S_WAIT) || (state_q == S_HALTED) || (state_q == S_ERR);

    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvld_q;
    assign halted_o      = halted_q;
    assign err_o         = err_q;
    assign acc_cnt_o     = acc_cnt_q;

endmodule

// File: tb/tb_dmem_sequencer.sv
// Bench for dmem_sequencer: transaction-level model checked every cycle, plus literal checks.
module tb_dmem_sequencer;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        mem_read_i, mem_write_i, halt_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, stall_o, halted_o, err_o;
    logic [15:0] acc_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    dmem_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .halt_i(halt_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .stall_o(stall_o), .halted_o(halted_o), .err_o(err_o),
        .acc_cnt_o(acc_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: an access is in flight, just finished, or the core is stopped.
    logic        m_busy = 0, m_done = 0, m_done_read = 0, m_err = 0, m_halt = 0, m_we = 0;
    int          m_wait = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [15:0] m_cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_done_read <= 0; m_err <= 0; m_halt <= 0; m_we <= 0;
            m_wait <= 0; m_addr <= 0; m_wdata <= 0; m_rdata <= 0; m_cnt <= 0;
        end else if (m_err || m_halt) begin
            m_busy <= 0;
        end else if (m_done) begin
            m_done      <= 0;
            m_done_read <= 0;
        end else if (m_busy) begin
            if (mem_ack_i) begin
                m_busy      <= 0;
                m_done      <= 1;
                m_done_read <= !m_we;
                if (!m_we) m_rdata <= mem_rdata_i;
                m_cnt       <= m_cnt + 16'd1;
            end else if (m_wait + 1 == TIMEOUT) begin
                m_busy <= 0;
                m_err  <= 1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (mem_read_i && mem_write_i) begin
            m_err <= 1;
        end else if (mem_read_i || mem_write_i) begin
            m_busy  <= 1;
            m_we    <= mem_write_i;
            m_addr  <= addr_i;
            m_wdata <= wdata_i;
            m_wait  <= 0;
        end else if (halt_i) begin
            m_halt <= 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("req", mem_req_o, m_busy);
            chk("stall", stall_o, m_err | m_halt | m_busy | (!m_done & (mem_read_i | mem_write_i)));
            chk("rvalid", rdata_valid_o, m_done & m_done_read);
            chk("rdata", rdata_o, m_rdata);
            chk("halted", halted_o, m_halt);
            chk("err", err_o, m_err);
            chk("acc_cnt", acc_cnt_o, m_cnt);
            if (m_busy) begin
                chk("we", mem_we_o, m_we);
                chk("addr", mem_addr_o, m_addr);
                chk("wdata", mem_wdata_o, m_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One access with ack in WAIT cycle ack_k; addr/wdata inputs are scrambled during WAIT.
    task automatic run_access(input logic is_rd, input logic [31:0] a, input logic [31:0] wd,
                              input int ack_k, input logic [31:0] rd_val,
                              output int stalls, output int pulses);
        stalls = 0;
        pulses = 0;
        mem_read_i  = is_rd;
        mem_write_i = !is_rd;
        addr_i      = a;
        wdata_i     = wd;
        @(negedge clk);
        stalls += int'(stall_o); pulses += int'(rdata_valid_o);
        tick();
        addr_i  = ~a;
        wdata_i = ~wd;
        for (int k = 1; k <= ack_k; k++) begin
            if (k == ack_k) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd_val;
            end
            @(negedge clk);
            stalls += int'(stall_o); pulses += int'(rdata_valid_o);
            tick();
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'h0BAD_0BAD;
        end
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        @(negedge clk);
        stalls += int'(stall_o); pulses += int'(rdata_valid_o);
        tick();
        @(negedge clk);
        stalls += int'(stall_o); pulses += int'(rdata_valid_o);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_read_i = 0; mem_write_i = 0; halt_i = 0; mem_ack_i = 0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    int st, pl, reqs;

    initial begin
        reset = 1'b1;
        mem_read_i = 0; mem_write_i = 0; halt_i = 0; mem_ack_i = 0;
        addr_i = 0; wdata_i = 0; mem_rdata_i = 0;
        @(posedge clk);
        #1 started = 1'b1;
        mem_read_i = 1'b1;
        @(negedge clk);
        chk("lit_reset_req", mem_req_o, 0);
        chk("lit_reset_stall", stall_o, 1);
        chk("lit_reset_acc", acc_cnt_o, 0);
        tick();
        mem_read_i = 1'b0;
        reset = 1'b0;
        tick();

        run_access(1'b1, 32'h100, 32'h0, 3, 32'hDEADBEEF, st, pl);
        chk("lit_load_stalls", st, 4);
        chk("lit_load_pulses", pl, 1);
        chk("lit_load_rdata", rdata_o, 32'hDEADBEEF);
        chk("lit_load_acc", acc_cnt_o, 1);

        run_access(1'b0, 32'h40, 32'h12345678, 1, 32'hFFFF_0000, st, pl);
        chk("lit_store_stalls", st, 2);
        chk("lit_store_pulses", pl, 0);
        chk("lit_store_rdata", rdata_o, 32'hDEADBEEF);
        chk("lit_store_acc", acc_cnt_o, 2);

        run_access(1'b1, 32'h2004, 32'h0, 2, 32'hA5A5_0001, st, pl);
        chk("lit_load2_stalls", st, 3);
        chk("lit_load2_rdata", rdata_o, 32'hA5A5_0001);

        mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        tick();
        mem_ack_i = 1'b0;
        tick();
        chk("lit_stray_ack_acc", acc_cnt_o, 3);
        chk("lit_stray_ack_rdata", rdata_o, 32'hA5A5_0001);

        halt_i = 1'b1;
        run_access(1'b1, 32'h300, 32'h0, 1, 32'h0000_CAFE, st, pl);
        chk("lit_halt_op_first_acc", acc_cnt_o, 4);
        chk("lit_halted", halted_o, 1);
        chk("lit_halted_stall", stall_o, 1);
        halt_i = 1'b0;
        mem_read_i = 1'b1; addr_i = 32'h500;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); reqs += int'(mem_req_o);
            tick();
        end
        mem_read_i = 1'b0;
        chk("lit_halted_no_req", reqs, 0);

        do_reset();
        mem_read_i = 1'b1; mem_write_i = 1'b1; addr_i = 32'h600;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); reqs += int'(mem_req_o);
            tick();
        end
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        chk("lit_both_no_req", reqs, 0);
        chk("lit_both_err", err_o, 1);

        do_reset();
        mem_read_i = 1'b1; addr_i = 32'h700;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); reqs += int'(mem_req_o);
            tick();
        end
        chk("lit_timeout_req_cycles", reqs, 15);
        mem_read_i = 1'b0;
        tick();
        chk("lit_timeout_err", err_o, 1);
        chk("lit_timeout_stall", stall_o, 1);

        do_reset();
        mem_read_i = 1'b1; addr_i = 32'h800;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("lit_midwait_req", mem_req_o, 0);
        chk("lit_midwait_acc", acc_cnt_o, 0);
        mem_read_i = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_access(1'b1, 32'h900, 32'h0, 1, 32'h1357_9BDF, st, pl);
        chk("lit_after_reset_acc", acc_cnt_o, 1);
        chk("lit_after_reset_rdata", rdata_o, 32'h1357_9BDF);
        chk("lit_after_reset_pulses", pl, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
